// File: rtl/rf_write_arbiter_if.sv
// Write-port bundle for rf_write_arbiter: the two writeback requesters
// (ALU, load) and the registered WE3/A3/WD3 register-file write port.
// Build option: RF_WRITE_FWD_EN adds the read-forwarding signals.
interface rf_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 5
);
  logic                  alu_valid;
  logic [DEPTH-1:0]      alu_addr;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_ready;
  logic                  mem_valid;
  logic [DEPTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ready;
  logic                  WE3;
  logic [DEPTH-1:0]      A3;
  logic [DATA_WIDTH-1:0] WD3;
  logic                  init_done;
`ifdef RF_WRITE_FWD_EN
  logic [DEPTH-1:0]      rd_a1;
  logic [DEPTH-1:0]      rd_a2;
  logic [DATA_WIDTH-1:0] rf_rd1;
  logic [DATA_WIDTH-1:0] rf_rd2;
  logic [DATA_WIDTH-1:0] fwd_rd1;
  logic [DATA_WIDTH-1:0] fwd_rd2;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output rd_a1, rd_a2, rf_rd1, rf_rd2,
    input  alu_ready, mem_ready, WE3, A3, WD3, init_done, fwd_rd1, fwd_rd2
  );
  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  rd_a1, rd_a2, rf_rd1, rf_rd2,
    output alu_ready, mem_ready, WE3, A3, WD3, init_done, fwd_rd1, fwd_rd2
  );
`else
  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, WE3, A3, WD3, init_done
  );
  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, WE3, A3, WD3, init_done
  );
`endif
endinterface

// File: rtl/rf_write_arbiter.sv
// Owner of the register-file write port. After reset it clears every
// register (one write per cycle), then shares the port round-robin between
// ALU writeback and load writeback. Writes to $0 are handshaken but dropped.
// Build option: RF_WRITE_FWD_EN adds combinational write-to-read forwarding.
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 5
) (
  input logic             clk,
  input logic             rst_n,
  rf_write_arbiter_if.slave bus
);
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  // Extra top bit marks "all registers cleared" without wrapping to 0.
  logic [DEPTH:0]        cnt_q, cnt_d;
  // Last-grant pointer: 0 = ALU, 1 = load.
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic [DEPTH-1:0]      a3_q, a3_d;
  logic [DATA_WIDTH-1:0] wd3_q, wd3_d;
  logic                  done_q, done_d;
  logic                  alu_gnt, mem_gnt;

  // State register: all sequential state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
      done_q  <= done_d;
    end
  end

  // Next-state: walk the clear counter, then park in RUN until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q[DEPTH]) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + {{DEPTH{1'b0}}, 1'b1};
      end
    end
  end

  // Outputs: grants and the next write-port contents.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    we_d    = 1'b0;
    a3_d    = a3_q;
    wd3_d   = wd3_q;
    last_d  = last_q;
    done_d  = done_q;
    case (state_q)
      ST_INIT: begin
        if (!cnt_q[DEPTH]) begin
          we_d  = 1'b1;
          a3_d  = cnt_q[DEPTH-1:0];
          wd3_d = '0;
        end else begin
          done_d = 1'b1;
        end
      end
      ST_RUN: begin
        // On conflict the port not granted last time wins.
        alu_gnt = bus.alu_valid && (!bus.mem_valid || last_q);
        mem_gnt = bus.mem_valid && (!bus.alu_valid || !last_q);
        if (alu_gnt) begin
          we_d   = |bus.alu_addr;
          a3_d   = bus.alu_addr;
          wd3_d  = bus.alu_data;
          last_d = 1'b0;
        end else if (mem_gnt) begin
          we_d   = |bus.mem_addr;
          a3_d   = bus.mem_addr;
          wd3_d  = bus.mem_data;
          last_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.alu_ready = alu_gnt;
  assign bus.mem_ready = mem_gnt;
  assign bus.WE3       = we_q;
  assign bus.A3        = a3_q;
  assign bus.WD3       = wd3_q;
  assign bus.init_done = done_q;

`ifdef RF_WRITE_FWD_EN
  // A read of the register being written this cycle sees the new value.
  assign bus.fwd_rd1 = (we_q && (a3_q == bus.rd_a1) && (bus.rd_a1 != '0)) ? wd3_q : bus.rf_rd1;
  assign bus.fwd_rd2 = (we_q && (a3_q == bus.rd_a2) && (bus.rd_a2 != '0)) ? wd3_q : bus.rf_rd2;
`endif
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port (WE3/A3/WD3) of the multicycle MIPS Register_File.
- Shares that port between two writeback requesters: ALU result writeback (port 0) and memory-load writeback (port 1).
- After reset, sequences a clear of every register, then arbitrates round-robin with valid/ready handshakes and suppresses writes to $0.

Parameters:
- DATA_WIDTH, 32, register data width.
- DEPTH, 5, register address width; the file holds 2**DEPTH entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_addr  in  DEPTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- alu_ready  out  1  ALU request accepted this cycle (combinational).
- mem_valid  in  1  load writeback request.
- mem_addr  in  DEPTH  load destination register.
- mem_data  in  DATA_WIDTH  load data.
- mem_ready  out  1  load request accepted this cycle (combinational).
- WE3  out  1  register-file write enable (registered).
- A3  out  DEPTH  register-file write address (registered).
- WD3  out  DATA_WIDTH  register-file write data (registered).
- init_done  out  1  clear sequence complete (registered).

Behaviour:
- Reset (rst_n low, async) values:
  - Outputs: WE3=0, A3=0, WD3=0, init_done=0.
  - Internal: state=INIT, init counter=0, last-grant pointer=1, so port 0 wins the first conflict.
- State INIT:
  - Each clock loads WE3=1, A3=counter, WD3=0, then increments the counter.
  - After the write with A3=2**DEPTH-1, the next edge loads WE3=0, sets init_done=1 and moves to RUN.
  - Total: 2**DEPTH write cycles; init_done rises on edge 2**DEPTH+1 after reset release.
  - alu_ready and mem_ready are held at 0 throughout INIT; valids are ignored and not queued.
- State RUN grant rule:
  - Only alu_valid high: alu_ready=1.
  - Only mem_valid high: mem_ready=1.
  - Both high: grant the port not named by the last-grant pointer.
  - Neither high: no grant.
  - At most one ready is high in any cycle.
  - The pointer updates to the accepted port on every accept, conflict or not.
- Handshake:
  - A transfer occurs when valid and ready are both high at a rising edge.
  - Requesters hold addr/data stable while valid is high and not ready.
  - A requester must not drop valid before it is accepted.
- Latency:
  - Accept at edge k drives WE3/A3/WD3 with the accepted addr/data during cycle k+1.
  - The register file commits the write on edge k+1.
  - Back-to-back accepts give back-to-back writes: one write per cycle, no bubbles.
- $0 rule: an accepted request with addr=0 is handshaken normally (ready=1, pointer updates), but the next cycle has WE3=0. A3/WD3 still load the request values.
- Idle: a cycle with no accept loads WE3=0; A3 and WD3 hold their previous values.
- Reset mid-operation: reset in INIT or RUN returns to INIT with counter 0, and the full clear sequence reruns. A WE3 pulse in progress is cleared asynchronously.
- No state beyond INIT and RUN. RUN is terminal until reset.

Optional Feature:
- Macro: RF_WRITE_FWD_EN
- Defined: adds these ports:
  - rd_a1 in DEPTH, rd_a2 in DEPTH (read addresses).
  - rf_rd1 in DATA_WIDTH, rf_rd2 in DATA_WIDTH (raw RD1/RD2 from the file).
  - fwd_rd1 out DATA_WIDTH, fwd_rd2 out DATA_WIDTH.
- Forwarding logic (combinational):
  - fwd_rd1 = WD3 when WE3=1, A3==rd_a1 and rd_a1!=0; otherwise rf_rd1. Same for fwd_rd2 with rd_a2/rf_rd2.
  - This hides same-cycle write-then-read hazards.
- Undefined: these ports and this logic do not exist; the port list is exactly as above.

Test Plan:
- Release rst_n with no requests:
  - WE3=1 for 32 consecutive cycles with A3=0..31 and WD3=0.
  - Then WE3=0 and init_done=1.
  - Readies stay 0 throughout, even with alu_valid held 1.
- In RUN, alu_valid=1, alu_addr=5, alu_data=32'h0000_0032 for one cycle:
  - alu_ready=1 that cycle.
  - Next cycle WE3=1, A3=5, WD3=32'h32.
  - Cycle after that WE3=0.
- Both valid continuously (alu addr 3/data 30, mem addr 4/data 40, each request re-presented after acceptance):
  - Grants alternate ALU, MEM, ALU, MEM.
  - WE3 high every cycle with A3 sequence 3,4,3,4.
- mem_valid=1, mem_addr=0, mem_data=32'hDEAD_BEEF: mem_ready=1 and the next cycle WE3=0.
- Assert rst_n low midway through INIT (A3=12) and mid-RUN write:
  - WE3 and init_done drop to 0 immediately.
  - After release, A3 restarts at 0.
- With RF_WRITE_FWD_EN:
  - Setup: WE3=1, A3=7, WD3=70, rd_a1=7, rf_rd1=0 → fwd_rd1=70.
  - rd_a2=8, rf_rd2=80 → fwd_rd2=80.
  - With A3=0, rd_a1=0: fwd_rd1=rf_rd1.
